bank_arbiter: RTL

Single-clock arbiter that shares the multi-bank dual-port latency memory between two requesters. Requester 0 is steered to memory port A and requester 1 to port B. Same-cycle accesses that hit the same bank are serialized with a round-robin priority pointer. Read data is returned with a valid strobe aligned to the memory's read latency. It sits between the system-side requesters and the memory top's port pins.

---
 rtl/bank_arbiter_pkg.sv | 17 +
 rtl/rd_return_tracker.sv | 32 +++
 rtl/bank_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bank_arbiter_pkg.sv
// Shared defaults for the two-requester bank arbiter and the requester id type
// used by the round-robin priority pointer.
package bank_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MEM_DEPTH  = 64;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_BANK_W     = $clog2(DEF_NUM_BANKS);
  localparam int NUM_PORTS      = 2;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/rd_return_tracker.sv
// Per-port read-return tracker: delays the "read issued" strobe by the memory
// read latency and passes the memory read data straight through.
module rd_return_tracker #(
  parameter int RD_LATENCY = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [RD_LATENCY-1:0] vld_pipe;

  // Stage 0 captures the registered command, so the tap lines up with data
  // appearing RD_LATENCY edges after the command is presented to memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= en & ~we;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign rvalid = vld_pipe[RD_LATENCY-1];
  assign rdata  = dout;

endmodule

// File: rtl/bank_arbiter.sv
// Two-requester arbiter onto a dual-port banked memory: requester 0 -> port A,
// requester 1 -> port B, same-bank collisions resolved round-robin.
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter  int NUM_BANKS  = DEF_NUM_BANKS,
  parameter  int RD_LATENCY = DEF_RD_LATENCY,
  localparam int ADDR_W     = $clog2(MEM_DEPTH),
  localparam int BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid_0,
  input  logic                  i_valid_1,
  input  logic                  i_we_0,
  input  logic                  i_we_1,
  input  logic [ADDR_W-1:0]     i_addr_0,
  input  logic [ADDR_W-1:0]     i_addr_1,
  input  logic [DATA_WIDTH-1:0] i_wdata_0,
  input  logic [DATA_WIDTH-1:0] i_wdata_1,
  output logic                  o_ready_0,
  output logic                  o_ready_1,
  output logic                  o_rvalid_0,
  output logic                  o_rvalid_1,
  output logic [DATA_WIDTH-1:0] o_rdata_0,
  output logic [DATA_WIDTH-1:0] o_rdata_1,
  output logic                  o_ena,
  output logic                  o_wea,
  output logic [ADDR_W-1:0]     o_addra,
  output logic [DATA_WIDTH-1:0] o_dina,
  output logic                  o_enb,
  output logic                  o_web,
  output logic [ADDR_W-1:0]     o_addrb,
  output logic [DATA_WIDTH-1:0] o_dinb,
  input  logic [DATA_WIDTH-1:0] i_douta,
  input  logic [DATA_WIDTH-1:0] i_doutb,
  output logic [15:0]           o_conflict_cnt
);

  logic [NUM_PORTS-1:0]                 valid, we, ready, accept;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]     addr, addr_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata, din_q, dout, rdata;
  logic [NUM_PORTS-1:0]                 en_q, we_q, rvalid;
  logic [BANK_W-1:0]                    bank_0, bank_1;
  logic                                 conflict;
  req_id_t                              prio;
  logic [15:0]                          conflict_cnt;

  assign valid = {i_valid_1, i_valid_0};
  assign we    = {i_we_1, i_we_0};
  assign addr  = {i_addr_1, i_addr_0};
  assign wdata = {i_wdata_1, i_wdata_0};
  assign dout  = {i_doutb, i_douta};

  assign bank_0   = i_addr_0[ADDR_W-1 -: BANK_W];
  assign bank_1   = i_addr_1[ADDR_W-1 -: BANK_W];
  assign conflict = i_valid_0 && i_valid_1 && (bank_0 == bank_1);

  // Idle or non-colliding requesters always see ready; only the loser stalls.
  assign ready[0] = !conflict || (prio == REQ0);
  assign ready[1] = !conflict || (prio == REQ1);
  assign accept   = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        en_q[p] <= accept[p];
        we_q[p] <= accept[p] & we[p];
        if (accept[p]) begin
          addr_q[p] <= addr[p];
          din_q[p]  <= wdata[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio         <= REQ0;
      conflict_cnt <= '0;
    end else if (conflict) begin
      prio <= (prio == REQ0) ? REQ1 : REQ0;
      if (conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_trk
    rd_return_tracker #(
      .RD_LATENCY(RD_LATENCY),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_trk (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_q[p]),
      .we    (we_q[p]),
      .dout  (dout[p]),
      .rvalid(rvalid[p]),
      .rdata (rdata[p])
    );
  end

  assign o_ready_0      = ready[0];
  assign o_ready_1      = ready[1];
  assign o_rvalid_0     = rvalid[0];
  assign o_rvalid_1     = rvalid[1];
  assign o_rdata_0      = rdata[0];
  assign o_rdata_1      = rdata[1];
  assign o_ena          = en_q[0];
  assign o_wea          = we_q[0];
  assign o_addra        = addr_q[0];
  assign o_dina         = din_q[0];
  assign o_enb          = en_q[1];
  assign o_web          = we_q[1];
  assign o_addrb        = addr_q[1];
  assign o_dinb         = din_q[1];
  assign o_conflict_cnt = conflict_cnt;

endmodule
